// File: rtl/tm1638_key_event.sv
// tm1638_key_event
// Post-processing for the TM1638 key scan result. Each key is debounced on a
// slow sample tick, then turned into press / release / auto-repeat strobes, an
// encoded key event, and a per-key toggle bit for driving LEDs.
//
// Ports:
//   CK_i          clock (same domain as the TM1638 driver)
//   ARST_i        asynchronous reset, active high
//   KEYS_i[7:0]   raw key levels, 1 = pressed
//   CLR_TOGGLE_i  synchronous clear of TOGGLE_o
//   KEYS_o[7:0]   debounced key levels
//   PRESS_o[7:0]  one-cycle pulse on accepted press
//   RELEASE_o[7:0] one-cycle pulse on accepted release
//   REPEAT_o[7:0] one-cycle pulse on auto-repeat
//   KEY_EV_o      pulse when any press or repeat occurred the cycle before
//   KEY_CODE_o    lowest key index of the last event (held)
//   KEY_MULTI_o   more than one key in the event
//   TOGGLE_o[7:0] per-key bit flipped on each press
//   TICK_o        debounce sample tick
module tm1638_key_event #(
    parameter int C_FCK     = 48_000_000,
    parameter int C_FSMP    = 1_000,
    parameter int C_DB_SMP  = 8,
    parameter int C_RPT_DLY = 500,
    parameter int C_RPT_PER = 100
) (
    input  logic       CK_i,
    input  logic       ARST_i,
    input  logic [7:0] KEYS_i,
    input  logic       CLR_TOGGLE_i,
    output logic [7:0] KEYS_o,
    output logic [7:0] PRESS_o,
    output logic [7:0] RELEASE_o,
    output logic [7:0] REPEAT_o,
    output logic       KEY_EV_o,
    output logic [2:0] KEY_CODE_o,
    output logic       KEY_MULTI_o,
    output logic [7:0] TOGGLE_o,
    output logic       TICK_o
);

    localparam int PRE_TC  = C_FCK / C_FSMP - 1;
    localparam int PW      = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
    localparam int DBW     = (C_DB_SMP > 0) ? $clog2(C_DB_SMP + 1) : 1;
    localparam int RW      = (C_RPT_DLY > 0) ? $clog2(C_RPT_DLY + 1) : 1;
    localparam bit RPT_EN  = (C_RPT_DLY > 0);
    localparam int RLD_VAL = (C_RPT_DLY >= C_RPT_PER) ? (C_RPT_DLY - C_RPT_PER) : 0;

    localparam logic [PW-1:0]  PRE_TC_V = PW'(PRE_TC);
    localparam logic [DBW-1:0] DB_TC    = DBW'(C_DB_SMP);
    localparam logic [RW-1:0]  RPT_TC   = RW'(C_RPT_DLY);
    localparam logic [RW-1:0]  RPT_RLD  = RW'(RLD_VAL);

    // Lowest set bit index of an event vector.
    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = v[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    // True when more than one bit is set (clearing the lowest leaves a bit).
    function automatic logic multi_bit(input logic [7:0] v);
        return |(v & (v - 8'd1));
    endfunction

    logic [PW-1:0]  pre_cnt_r;
    logic           tick_r;
    logic [DBW-1:0] db_cnt_r  [8];
    logic [DBW-1:0] db_nxt_s  [8];
    logic [RW-1:0]  rpt_cnt_r [8];
    logic [RW-1:0]  rpt_nxt_s [8];
    logic [7:0]     keys_r;
    logic [7:0]     keys_nxt_s;
    logic [7:0]     press_r;
    logic [7:0]     press_s;
    logic [7:0]     release_r;
    logic [7:0]     release_s;
    logic [7:0]     repeat_r;
    logic [7:0]     repeat_s;
    logic [7:0]     toggle_r;
    logic [7:0]     ev_s;
    logic           key_ev_r;
    logic [2:0]     key_code_r;
    logic           key_multi_r;

    // Sample-rate prescaler; tick is registered off the terminal count.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            pre_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            tick_r    <= (pre_cnt_r == PRE_TC_V);
            pre_cnt_r <= (pre_cnt_r == PRE_TC_V) ? '0 : pre_cnt_r + PW'(1);
        end
    end

    // Per-key debounce and repeat next-state, evaluated only on tick cycles.
    always_comb begin
        keys_nxt_s = keys_r;
        press_s    = 8'h00;
        release_s  = 8'h00;
        repeat_s   = 8'h00;
        for (int k = 0; k < 8; k++) begin
            db_nxt_s[k]  = db_cnt_r[k];
            rpt_nxt_s[k] = rpt_cnt_r[k];
            if (tick_r) begin
                if (KEYS_i[k] != keys_r[k]) begin
                    if ((db_cnt_r[k] + DBW'(1)) == DB_TC) begin
                        keys_nxt_s[k] = KEYS_i[k];
                        db_nxt_s[k]   = '0;
                        press_s[k]    = KEYS_i[k];
                        release_s[k]  = ~KEYS_i[k];
                    end else begin
                        db_nxt_s[k]   = db_cnt_r[k] + DBW'(1);
                    end
                end else begin
                    db_nxt_s[k] = '0;
                end
                // An accepted edge restarts the repeat count, so a repeat
                // can never coincide with that key's press or release.
                if (!RPT_EN) begin
                    rpt_nxt_s[k] = '0;
                end else if (press_s[k] || release_s[k]) begin
                    rpt_nxt_s[k] = '0;
                end else if (keys_r[k]) begin
                    if ((rpt_cnt_r[k] + RW'(1)) == RPT_TC) begin
                        repeat_s[k]  = 1'b1;
                        rpt_nxt_s[k] = RPT_RLD;
                    end else begin
                        rpt_nxt_s[k] = rpt_cnt_r[k] + RW'(1);
                    end
                end else begin
                    rpt_nxt_s[k] = '0;
                end
            end else begin
                db_nxt_s[k]  = db_cnt_r[k];
                rpt_nxt_s[k] = rpt_cnt_r[k];
            end
        end
    end

    // Debounced levels, counters and the edge / repeat strobes.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            keys_r    <= 8'h00;
            press_r   <= 8'h00;
            release_r <= 8'h00;
            repeat_r  <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                db_cnt_r[k]  <= '0;
                rpt_cnt_r[k] <= '0;
            end
        end else begin
            keys_r    <= keys_nxt_s;
            press_r   <= press_s;
            release_r <= release_s;
            repeat_r  <= repeat_s;
            for (int k = 0; k < 8; k++) begin
                db_cnt_r[k]  <= db_nxt_s[k];
                rpt_cnt_r[k] <= rpt_nxt_s[k];
            end
        end
    end

    assign ev_s = press_r | repeat_r;

    // Key event encoder; the code is held between events.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            key_ev_r    <= 1'b0;
            key_code_r  <= 3'd0;
            key_multi_r <= 1'b0;
        end else if (|ev_s) begin
            key_ev_r    <= 1'b1;
            key_code_r  <= low_idx(ev_s);
            key_multi_r <= multi_bit(ev_s);
        end else begin
            key_ev_r    <= 1'b0;
            key_multi_r <= 1'b0;
        end
    end

    // Toggle bits; clear wins over a flip in the same cycle.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            toggle_r <= 8'h00;
        end else if (CLR_TOGGLE_i) begin
            toggle_r <= 8'h00;
        end else begin
            toggle_r <= toggle_r ^ press_r;
        end
    end

    assign KEYS_o      = keys_r;
    assign PRESS_o     = press_r;
    assign RELEASE_o   = release_r;
    assign REPEAT_o    = repeat_r;
    assign KEY_EV_o    = key_ev_r;
    assign KEY_CODE_o  = key_code_r;
    assign KEY_MULTI_o = key_multi_r;
    assign TOGGLE_o    = toggle_r;
    assign TICK_o      = tick_r;

endmodule

// File: tb/tb_tm1638_key_event.sv
// Self-checking bench for tm1638_key_event with a tick every 10 cycles,
// 3-sample debounce, first repeat after 5 ticks and then every 2 ticks.
module tb_tm1638_key_event;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] keys_in = 8'h00;
    logic       clr_toggle = 1'b0;
    logic [7:0] keys_out, press, rel, rpt, toggle;
    logic       key_ev, key_multi, tick;
    logic [2:0] key_code;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] keys_in;
        int         ticks;
        logic [7:0] e_keys;
        logic [7:0] e_press;
        logic [7:0] e_rel;
        logic [7:0] e_tog;
        logic       e_ev;
        logic [2:0] e_code;
        logic       e_multi;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        logic       multi;
    } ev_t;

    vec_t vecs [11];
    ev_t  sb_q [$];

    tm1638_key_event #(
        .C_FCK(1000), .C_FSMP(100), .C_DB_SMP(3), .C_RPT_DLY(5), .C_RPT_PER(2)
    ) dut (
        .CK_i(clk), .ARST_i(arst), .KEYS_i(keys_in), .CLR_TOGGLE_i(clr_toggle),
        .KEYS_o(keys_out), .PRESS_o(press), .RELEASE_o(rel), .REPEAT_o(rpt),
        .KEY_EV_o(key_ev), .KEY_CODE_o(key_code), .KEY_MULTI_o(key_multi),
        .TOGGLE_o(toggle), .TICK_o(tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    // Consume n tick cycles; returns just after the edge that ends the last one.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            while (tick !== 1'b1 && guard < 20) begin
                cyc();
                guard++;
            end
            if (guard >= 20) fail("tick_timeout");
            cyc();
        end
    endtask

    // Compare the event outputs; any event pops the scoreboard.
    task automatic check_ev(input logic exp_ev);
        ev_t e;
        chk("key_ev", {31'd0, key_ev}, {31'd0, exp_ev});
        if (key_ev === 1'b1) begin
            if (sb_q.size() == 0) begin
                fail("unexpected_event");
            end else begin
                e = sb_q.pop_front();
                chk("key_code", {29'd0, key_code}, {29'd0, e.code});
                chk("key_multi", {31'd0, key_multi}, {31'd0, e.multi});
            end
        end
    endtask

    initial begin
        int ticks_seen;
        int c;
        logic exp_rep;

        vecs[0]  = '{8'h04, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{8'h04, 1, 8'h04, 8'h04, 8'h00, 8'h04, 1'b1, 3'd2, 1'b0};
        vecs[2]  = '{8'h00, 3, 8'h00, 8'h00, 8'h04, 8'h04, 1'b0, 3'd2, 1'b0};
        vecs[3]  = '{8'h04, 2, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0, 3'd2, 1'b0};
        vecs[4]  = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0, 3'd2, 1'b0};
        vecs[5]  = '{8'h04, 2, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0, 3'd2, 1'b0};
        vecs[6]  = '{8'h00, 2, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0, 3'd2, 1'b0};
        vecs[7]  = '{8'h81, 3, 8'h81, 8'h81, 8'h00, 8'h85, 1'b1, 3'd0, 1'b1};
        vecs[8]  = '{8'h00, 3, 8'h00, 8'h00, 8'h81, 8'h85, 1'b0, 3'd0, 1'b0};
        vecs[9]  = '{8'h0A, 3, 8'h0A, 8'h0A, 8'h00, 8'h8F, 1'b1, 3'd1, 1'b1};
        vecs[10] = '{8'h00, 3, 8'h00, 8'h00, 8'h0A, 8'h8F, 1'b0, 3'd1, 1'b0};

        // Reset state
        repeat (3) cyc();
        chk("rst_keys", {24'd0, keys_out}, 32'd0);
        chk("rst_strobes", {8'd0, press, rel, rpt}, 32'd0);
        chk("rst_enc", {27'd0, key_ev, key_code, key_multi}, 32'd0);
        chk("rst_toggle_tick", {23'd0, toggle, tick}, 32'd0);

        // Tick cadence after reset release
        arst = 1'b0;
        ticks_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (tick === 1'b1) ticks_seen++;
            if (i == 9)  chk("tick_c9", {31'd0, tick}, 32'd0);
            if (i == 10) chk("tick_c10", {31'd0, tick}, 32'd1);
            if (i == 20) chk("tick_c20", {31'd0, tick}, 32'd1);
        end
        chk("tick_count", ticks_seen, 32'd2);
        cyc();

        // Table: debounce, glitch rejection, multi-key press/release
        for (int v = 0; v < 11; v++) begin
            keys_in = vecs[v].keys_in;
            run_ticks(vecs[v].ticks);
            chk($sformatf("v%0d_keys", v), {24'd0, keys_out}, {24'd0, vecs[v].e_keys});
            chk($sformatf("v%0d_press", v), {24'd0, press}, {24'd0, vecs[v].e_press});
            chk($sformatf("v%0d_release", v), {24'd0, rel}, {24'd0, vecs[v].e_rel});
            if (vecs[v].e_ev) sb_q.push_back('{vecs[v].e_code, vecs[v].e_multi});
            cyc();
            chk($sformatf("v%0d_press_off", v), {24'd0, press}, 32'd0);
            check_ev(vecs[v].e_ev);
            if (!vecs[v].e_ev)
                chk($sformatf("v%0d_code_held", v), {29'd0, key_code}, {29'd0, vecs[v].e_code});
            chk($sformatf("v%0d_toggle", v), {24'd0, toggle}, {24'd0, vecs[v].e_tog});
        end

        // Auto-repeat on key 0, including the release tick
        keys_in = 8'h01;
        run_ticks(3);
        chk("rp_press", {24'd0, press}, 32'h01);
        sb_q.push_back('{3'd0, 1'b0});
        cyc();
        check_ev(1'b1);
        chk("rp_toggle", {24'd0, toggle}, 32'h8E);
        for (int t = 1; t <= 27; t++) begin
            keys_in = (t <= 20) ? 8'h01 : 8'h00;
            run_ticks(1);
            exp_rep = (t >= 5) && (t % 2 == 1) && (t < 23);
            chk($sformatf("rp_t%0d_repeat", t), {24'd0, rpt}, {31'd0, exp_rep});
            chk($sformatf("rp_t%0d_release", t), {24'd0, rel}, (t == 23) ? 32'h01 : 32'h00);
            if (exp_rep) sb_q.push_back('{3'd0, 1'b0});
            cyc();
            check_ev(exp_rep);
        end
        chk("rp_keys_end", {24'd0, keys_out}, 32'h00);
        chk("rp_toggle_end", {24'd0, toggle}, 32'h8E);

        // Toggle clear coinciding with a press
        keys_in = 8'h10;
        run_ticks(3);
        chk("clr_press", {24'd0, press}, 32'h10);
        sb_q.push_back('{3'd4, 1'b0});
        clr_toggle = 1'b1;
        cyc();
        clr_toggle = 1'b0;
        chk("clr_toggle", {24'd0, toggle}, 32'h00);
        check_ev(1'b1);
        keys_in = 8'h00;
        run_ticks(3);
        chk("clr_release", {24'd0, rel}, 32'h10);
        cyc();
        chk("clr_toggle_after_rel", {24'd0, toggle}, 32'h00);

        // Reset in the middle of a debounce
        keys_in = 8'h20;
        run_ticks(2);
        chk("mr_pending", {24'd0, keys_out}, 32'h00);
        arst = 1'b1;
        cyc();
        chk("mr_rst_outs", {15'd0, keys_out, toggle, tick}, 32'd0);
        arst = 1'b0;
        c = 0;
        while (c < 15) begin
            cyc();
            c++;
            if (tick === 1'b1) break;
        end
        chk("mr_first_tick", c, 32'd10);
        run_ticks(2);
        chk("mr_not_yet", {24'd0, keys_out}, 32'h00);
        run_ticks(1);
        chk("mr_keys", {24'd0, keys_out}, 32'h20);
        chk("mr_press", {24'd0, press}, 32'h20);
        sb_q.push_back('{3'd5, 1'b0});
        cyc();
        check_ev(1'b1);
        chk("mr_toggle", {24'd0, toggle}, 32'h20);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
